frequency_divider_block: RTL and testbench
==========================================

# frequency_divider_block

Octave-selectable note-divisor table for the synthesizer's tone generators. It holds a 2-bit octave state and presents twelve 16-bit clock-divisor values, one per chromatic semitone C..B. Downstream oscillators count system clocks against these values. A one-cycle `octave` pulse steps the octave low → mid → high → low.

## Interface
- No parameters; divisor constants are fixed (system clock 10 MHz).
- `clk` in 1: system clock; all state updates on rising edge.
- `nrst` in 1: reset, synchronous, active-low.
- `octave` in 1: octave-advance request, sampled on every rising edge.
- `div0`..`div11` out 16 each: full-period divisor, in clk cycles, for semitone C (`div0`) through B (`div11`) of the current octave.

## Operation
- State: `oct_sel` (2 bits), values 0 = low, 1 = mid, 2 = high. Encoding 3 is illegal:
  - outputs decode it as 0;
  - the next advance goes to 1;
  - it is unreachable in normal operation.
- Transitions at a rising edge:
  - `nrst`=0 → 0. Reset has priority over `octave`.
  - Else `octave`=1 → next state: 0→1, 1→2, 2→0 (wrap).
  - Else hold.
- Level-sampled, no edge detection. `octave` held high for N edges advances N times, wrapping mod 3.
- Octave 0 divisors = round(10e6 / f) for C4..B4, `div0`..`div11`: 38222, 36077, 34052, 32141, 30337, 28635, 27027, 25511, 24079, 22727, 21452, 20248.
- Octave 1 divisors = each octave-0 value shifted right by 1, truncating: 19111, 18038, 17026, 16070, 15168, 14317, 13513, 12755, 12039, 11363, 10726, 10124.
- Octave 2 divisors = each octave-0 value shifted right by 2, truncating: 9555, 9019, 8513, 8035, 7584, 7158, 6756, 6377, 6019, 5681, 5363, 5062.
- All values are unsigned and fit in 16 bits. No arithmetic overflow is possible.
- Outputs are a pure combinational decode of `oct_sel`. No other state exists.

## Timing
- Reset: at the first rising edge with `nrst`=0, `oct_sel` becomes 0 and all `divN` equal the octave-0 values.
- Before the first reset edge, outputs are undefined.
- Latency: an advance sampled at edge k is visible on all twelve outputs after edge k, within the same cycle's combinational settle. All twelve change together; no mixed-octave cycle.
- Between edges, outputs are stable regardless of `octave` activity.
- Reset asserted mid-sequence (state 1 or 2) returns to 0 on that edge, even with `octave`=1.
- Releasing `nrst` while `octave`=1: the first edge with `nrst`=1 advances 0→1.

## Test plan
- Reset: hold `nrst`=0, `octave`=0, one edge → `div0`=38222, `div9`=22727, `div11`=20248.
- Single advance: release reset, pulse `octave`=1 for one edge → `div0`=19111, `div9`=11363, `div11`=10124. Further edges with `octave`=0 hold these values.
- Second advance: pulse again → `div0`=9555, `div9`=5681, `div11`=5062.
- Wrap: pulse from high octave → all twelve outputs return to octave-0 values (e.g. `div6`=27027).
- Held request: `octave`=1 for 4 consecutive edges from state 0 → state 1 (`div0`=19111).
- Reset priority: in state 2, apply `nrst`=0 and `octave`=1 at the same edge → state 0, `div0`=38222. Then release `nrst` with `octave`=1 → state 1 after the next edge.

Source files
------------

// File: rtl/frequency_divider_block.sv
// Octave-selectable note-divisor table for the tone generators.
// Holds a 2-bit octave selector and presents twelve 16-bit full-period
// divisors (C..B) for a 10 MHz system clock.
//
// state    | meaning
// ---------+--------------------------------------------------------
// OCT_LOW  | octave 0, base divisors (C4..B4)
// OCT_MID  | octave 1, base divisors >> 1
// OCT_HIGH | octave 2, base divisors >> 2
// OCT_BAD  | illegal encoding, decodes as octave 0, advances to OCT_MID
module frequency_divider_block (
  input  logic        clk,
  input  logic        nrst,
  input  logic        octave,
  output logic [15:0] div0,
  output logic [15:0] div1,
  output logic [15:0] div2,
  output logic [15:0] div3,
  output logic [15:0] div4,
  output logic [15:0] div5,
  output logic [15:0] div6,
  output logic [15:0] div7,
  output logic [15:0] div8,
  output logic [15:0] div9,
  output logic [15:0] div10,
  output logic [15:0] div11
);

  typedef enum logic [1:0] {
    OCT_LOW  = 2'd0,
    OCT_MID  = 2'd1,
    OCT_HIGH = 2'd2,
    OCT_BAD  = 2'd3
  } oct_e;

  // round(10e6 / f) for C4..B4; higher octaves are derived by truncating shifts
  localparam logic [15:0] BASE_DIV [12] = '{
    16'd38222, 16'd36077, 16'd34052, 16'd32141,
    16'd30337, 16'd28635, 16'd27027, 16'd25511,
    16'd24079, 16'd22727, 16'd21452, 16'd20248
  };

  oct_e        oct_sel_q;
  oct_e        oct_sel_d;
  logic [1:0]  shift;
  logic [15:0] div_arr [12];

  // Octave selector register; reset wins over an advance request
  always_ff @(posedge clk) begin
    if (!nrst) begin
      oct_sel_q <= OCT_LOW;
    end else begin
      oct_sel_q <= oct_sel_d;
    end
  end

  // Next octave: level-sampled advance, wrapping high back to low
  always_comb begin
    oct_sel_d = oct_sel_q;
    if (octave) begin
      case (oct_sel_q)
        OCT_LOW:  oct_sel_d = OCT_MID;
        OCT_MID:  oct_sel_d = OCT_HIGH;
        OCT_HIGH: oct_sel_d = OCT_LOW;
        default:  oct_sel_d = OCT_MID;
      endcase
    end
  end

  // Divisor decode; all twelve come from the same shift so they switch together
  always_comb begin
    shift = 2'd0;
    case (oct_sel_q)
      OCT_MID:  shift = 2'd1;
      OCT_HIGH: shift = 2'd2;
      default:  shift = 2'd0;
    endcase
    for (int i = 0; i < 12; i++) begin
      div_arr[i] = BASE_DIV[i] >> shift;
    end
  end

  assign div0  = div_arr[0];
  assign div1  = div_arr[1];
  assign div2  = div_arr[2];
  assign div3  = div_arr[3];
  assign div4  = div_arr[4];
  assign div5  = div_arr[5];
  assign div6  = div_arr[6];
  assign div7  = div_arr[7];
  assign div8  = div_arr[8];
  assign div9  = div_arr[9];
  assign div10 = div_arr[10];
  assign div11 = div_arr[11];

endmodule

// File: tb/tb_frequency_divider_block.sv
// Self-checking bench for frequency_divider_block: directed scenarios from
// the octave stepping rules plus a randomized run against a simple model.
module tb_frequency_divider_block;

  logic        clk;
  logic        nrst;
  logic        octave;
  logic [15:0] div0, div1, div2, div3, div4, div5;
  logic [15:0] div6, div7, div8, div9, div10, div11;
  logic [15:0] got [12];

  int total = 0;
  int bad   = 0;
  int m_oct = 0;

  // Octave-0 note divisors, round(10e6 / f) for C4..B4
  int base_t [12] = '{38222, 36077, 34052, 32141, 30337, 28635,
                      27027, 25511, 24079, 22727, 21452, 20248};

  frequency_divider_block dut (
    .clk(clk), .nrst(nrst), .octave(octave),
    .div0(div0), .div1(div1), .div2(div2), .div3(div3),
    .div4(div4), .div5(div5), .div6(div6), .div7(div7),
    .div8(div8), .div9(div9), .div10(div10), .div11(div11)
  );

  assign got[0]  = div0;  assign got[1]  = div1;  assign got[2]  = div2;
  assign got[3]  = div3;  assign got[4]  = div4;  assign got[5]  = div5;
  assign got[6]  = div6;  assign got[7]  = div7;  assign got[8]  = div8;
  assign got[9]  = div9;  assign got[10] = div10; assign got[11] = div11;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each octave up halves the period (integer division)
  function automatic logic [15:0] exp_div(input int oct, input int idx);
    int v;
    v = base_t[idx] / (1 << oct);
    return v[15:0];
  endfunction

  // Apply inputs, take one edge, advance the model by the same rule
  task automatic step(input logic r_n, input logic adv);
    nrst   = r_n;
    octave = adv;
    @(posedge clk);
    #1;
    if (!r_n) m_oct = 0;
    else if (adv) m_oct = (m_oct + 1) % 3;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0);
    total++;
    if (div0 !== 16'd38222) begin bad++; $display("FAIL reset_div0 got=%0d exp=38222", div0); end
    total++;
    if (div9 !== 16'd22727) begin bad++; $display("FAIL reset_div9 got=%0d exp=22727", div9); end
    total++;
    if (div11 !== 16'd20248) begin bad++; $display("FAIL reset_div11 got=%0d exp=20248", div11); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (got[i] !== exp_div(m_oct, i)) begin
        bad++; $display("FAIL reset_div%0d got=%0d exp=%0d", i, got[i], exp_div(m_oct, i));
      end
    end
  endtask

  task automatic test_single_advance();
    step(1'b1, 1'b1);
    total++;
    if (div0 !== 16'd19111) begin bad++; $display("FAIL adv1_div0 got=%0d exp=19111", div0); end
    total++;
    if (div9 !== 16'd11363) begin bad++; $display("FAIL adv1_div9 got=%0d exp=11363", div9); end
    total++;
    if (div11 !== 16'd10124) begin bad++; $display("FAIL adv1_div11 got=%0d exp=10124", div11); end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0);
      for (int i = 0; i < 12; i++) begin
        total++;
        if (got[i] !== exp_div(1, i)) begin
          bad++; $display("FAIL hold_mid_div%0d got=%0d exp=%0d", i, got[i], exp_div(1, i));
        end
      end
    end
  endtask

  task automatic test_second_advance();
    step(1'b1, 1'b1);
    total++;
    if (div0 !== 16'd9555) begin bad++; $display("FAIL adv2_div0 got=%0d exp=9555", div0); end
    total++;
    if (div9 !== 16'd5681) begin bad++; $display("FAIL adv2_div9 got=%0d exp=5681", div9); end
    total++;
    if (div11 !== 16'd5062) begin bad++; $display("FAIL adv2_div11 got=%0d exp=5062", div11); end
    // Toggling octave between edges must not disturb the outputs
    octave = 1'b1; #2; octave = 1'b0; #1;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (got[i] !== exp_div(2, i)) begin
        bad++; $display("FAIL midcycle_div%0d got=%0d exp=%0d", i, got[i], exp_div(2, i));
      end
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b1);
    total++;
    if (div6 !== 16'd27027) begin bad++; $display("FAIL wrap_div6 got=%0d exp=27027", div6); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (got[i] !== exp_div(0, i)) begin
        bad++; $display("FAIL wrap_div%0d got=%0d exp=%0d", i, got[i], exp_div(0, i));
      end
    end
  endtask

  task automatic test_held();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1);
      for (int i = 0; i < 12; i++) begin
        total++;
        if (got[i] !== exp_div(m_oct, i)) begin
          bad++; $display("FAIL held_edge%0d_div%0d got=%0d exp=%0d", k, i, got[i], exp_div(m_oct, i));
        end
      end
    end
    step(1'b1, 1'b0);
    total++;
    if (div0 !== 16'd19111) begin bad++; $display("FAIL held_final_div0 got=%0d exp=19111", div0); end
  endtask

  task automatic test_reset_priority();
    step(1'b1, 1'b1);
    total++;
    if (div0 !== 16'd9555) begin bad++; $display("FAIL prio_setup_div0 got=%0d exp=9555", div0); end
    step(1'b0, 1'b1);
    total++;
    if (div0 !== 16'd38222) begin bad++; $display("FAIL prio_reset_div0 got=%0d exp=38222", div0); end
    step(1'b1, 1'b1);
    total++;
    if (div0 !== 16'd19111) begin bad++; $display("FAIL prio_release_div0 got=%0d exp=19111", div0); end
    total++;
    if (div11 !== 16'd10124) begin bad++; $display("FAIL prio_release_div11 got=%0d exp=10124", div11); end
  endtask

  task automatic test_random();
    logic r_n, adv;
    for (int k = 0; k < 300; k++) begin
      r_n = ($urandom_range(0, 15) != 0);
      adv = $urandom_range(0, 1) == 1;
      step(r_n, adv);
      for (int i = 0; i < 12; i++) begin
        total++;
        if (got[i] !== exp_div(m_oct, i)) begin
          bad++; $display("FAIL random_c%0d_div%0d got=%0d exp=%0d", k, i, got[i], exp_div(m_oct, i));
        end
      end
    end
  endtask

  initial begin
    nrst   = 1'b0;
    octave = 1'b0;
    #2;
    test_reset();
    test_single_advance();
    test_second_advance();
    test_wrap();
    test_held();
    test_reset_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
